// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage PC unit.
// The next-PC source enum and the priority encoder that picks it.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_JUMP,
        PC_RET,
        PC_BRANCH
    } pc_sel_e;

    // Priority: branch > ret > jump > sequential; call only qualifies a winning jump.
    function automatic pc_sel_e pc_select(input logic branch_taken,
                                          input logic ret,
                                          input logic jump);
        if (branch_taken) begin
            return PC_BRANCH;
        end else if (ret) begin
            return PC_RET;
        end else if (jump) begin
            return PC_JUMP;
        end
        return PC_SEQ;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: top pointer plus occupancy count.
// Pushing when full overwrites the oldest entry; popping when empty only flags underflow.
module ras_stack
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  ptr_q, ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CntW'(DEPTH));
    // Never expose stale storage when nothing has been pushed.
    assign top       = empty ? '0 : mem_q[ptr_q];
    assign overflow  = ovf_q;
    assign underflow = udf_q;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        udf_d = 1'b0;
        if (push) begin
            ptr_d = ptr_q + 1'b1;
            cnt_d = full ? cnt_q : cnt_q + 1'b1;
            ovf_d = full;
        end else if (pop) begin
            if (empty) begin
                udf_d = 1'b1;
            end else begin
                ptr_d = ptr_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[ptr_d] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with branch/jump/call/return redirect and a return-address stack.
// The PC register and RAS both freeze under hold; reset overrides everything.
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int unsigned          WIDTH        = 32,
    parameter logic [WIDTH-1:0]     RESET_VECTOR = '0,
    parameter int unsigned          INC          = 4,
    parameter int unsigned          RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_underflow,
    output logic             ras_overflow
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_inc, pc_br, ras_top;
    logic             ras_push, ras_pop;
    pc_sel_e          sel;

    assign pc_inc = pc_q + WIDTH'(INC);
    assign pc_br  = pc_q + branch_offset;
    assign sel    = pc_select(branch_taken, ret, jump);

    // Only the winning request may touch the stack, so push and pop are exclusive.
    assign ras_push = !hold && (sel == PC_JUMP) && call;
    assign ras_pop  = !hold && (sel == PC_RET);

    always_comb begin
        pc_d = pc_q;
        if (!hold) begin
            unique case (sel)
                PC_BRANCH: pc_d = pc_br;
                PC_RET:    pc_d = ras_empty ? pc_inc : ras_top;
                PC_JUMP:   pc_d = jump_target;
                default:   pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

    ras_stack #(
        .WIDTH(WIDTH),
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk      (clk),
        .rst      (rst),
        .push     (ras_push),
        .pop      (ras_pop),
        .push_data(pc_inc),
        .top      (ras_top),
        .empty    (ras_empty),
        .full     (ras_full),
        .overflow (ras_overflow),
        .underflow(ras_underflow)
    );

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed vector bench for pc_unit_ras: a 32-bit instance driven from a table,
// plus a hand-written sequence on an 8-bit instance for wrap-around and reset during call.
module tb_pc_unit_ras;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // 32-bit instance
    logic        rst = 1'b1, hold = 1'b0, br = 1'b0, jmp = 1'b0, call = 1'b0, ret = 1'b0;
    logic [31:0] off = '0, tgt = '0;
    logic [31:0] pc;
    logic        e, f, uf, of;

    pc_unit_ras #(
        .WIDTH       (32),
        .RESET_VECTOR(32'h100),
        .INC         (4),
        .RAS_DEPTH   (4)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .branch_taken (br),
        .branch_offset(off),
        .jump         (jmp),
        .call         (call),
        .ret          (ret),
        .jump_target  (tgt),
        .pc           (pc),
        .ras_empty    (e),
        .ras_full     (f),
        .ras_underflow(uf),
        .ras_overflow (of)
    );

    // 8-bit instance
    logic       rst8 = 1'b1, br8 = 1'b0, jmp8 = 1'b0, call8 = 1'b0;
    logic [7:0] off8 = '0, tgt8 = '0;
    logic [7:0] pc8;
    logic       e8, f8, uf8, of8;

    pc_unit_ras #(
        .WIDTH       (8),
        .RESET_VECTOR(8'h20),
        .INC         (4),
        .RAS_DEPTH   (4)
    ) u_dut8 (
        .clk          (clk),
        .rst          (rst8),
        .hold         (1'b0),
        .branch_taken (br8),
        .branch_offset(off8),
        .jump         (jmp8),
        .call         (call8),
        .ret          (1'b0),
        .jump_target  (tgt8),
        .pc           (pc8),
        .ras_empty    (e8),
        .ras_full     (f8),
        .ras_underflow(uf8),
        .ras_overflow (of8)
    );

    typedef struct {
        string       tag;
        logic        rst, hold, br;
        logic [31:0] off;
        logic        jmp, call, ret;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        e, f, uf, of;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string tag, logic r, logic h, logic b, logic [31:0] o,
                                logic j, logic c, logic rt, logic [31:0] t,
                                logic [31:0] xpc, logic xe, logic xf, logic xuf, logic xof);
        vec_t v;
        v.tag = tag; v.rst = r; v.hold = h; v.br = b; v.off = o;
        v.jmp = j; v.call = c; v.ret = rt; v.tgt = t;
        v.pc = xpc; v.e = xe; v.f = xf; v.uf = xuf; v.of = xof;
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //   tag         rst h  br off            j  c  r  tgt           pc            e  f  uf of
        add("reset0",    1, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h100,      1, 0, 0, 0);
        add("reset1",    1, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h100,      1, 0, 0, 0);
        add("seq0",      0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h104,      1, 0, 0, 0);
        add("seq1",      0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h108,      1, 0, 0, 0);
        add("seq2",      0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h10C,      1, 0, 0, 0);
        add("jmp200",    0, 0, 0, 32'h0,         1, 0, 0, 32'h200,      32'h200,      1, 0, 0, 0);
        add("brprio",    0, 0, 1, 32'hFFFF_FFF8, 1, 1, 0, 32'h900,      32'h1F8,      1, 0, 0, 0);
        add("jmp40",     0, 0, 0, 32'h0,         1, 0, 0, 32'h40,       32'h40,       1, 0, 0, 0);
        add("call800",   0, 0, 0, 32'h0,         1, 1, 0, 32'h800,      32'h800,      0, 0, 0, 0);
        add("seq804",    0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h804,      0, 0, 0, 0);
        add("seq808",    0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h808,      0, 0, 0, 0);
        add("ret44",     0, 0, 0, 32'h0,         0, 0, 1, 32'h0,        32'h44,       1, 0, 0, 0);
        add("call300",   0, 0, 0, 32'h0,         1, 1, 0, 32'h300,      32'h300,      0, 0, 0, 0);
        add("retprio",   0, 0, 0, 32'h0,         1, 1, 1, 32'h900,      32'h48,       1, 0, 0, 0);
        add("jmp10",     0, 0, 0, 32'h0,         1, 0, 0, 32'h10,       32'h10,       1, 0, 0, 0);
        add("call20",    0, 0, 0, 32'h0,         1, 1, 0, 32'h20,       32'h20,       0, 0, 0, 0);
        add("call30",    0, 0, 0, 32'h0,         1, 1, 0, 32'h30,       32'h30,       0, 0, 0, 0);
        add("call40",    0, 0, 0, 32'h0,         1, 1, 0, 32'h40,       32'h40,       0, 0, 0, 0);
        add("call50",    0, 0, 0, 32'h0,         1, 1, 0, 32'h50,       32'h50,       0, 1, 0, 0);
        add("call60ovf", 0, 0, 0, 32'h0,         1, 1, 0, 32'h60,       32'h60,       0, 1, 0, 1);
        add("ret54",     0, 0, 0, 32'h0,         0, 0, 1, 32'h0,        32'h54,       0, 0, 0, 0);
        add("ret44b",    0, 0, 0, 32'h0,         0, 0, 1, 32'h0,        32'h44,       0, 0, 0, 0);
        add("ret34",     0, 0, 0, 32'h0,         0, 0, 1, 32'h0,        32'h34,       0, 0, 0, 0);
        add("ret24",     0, 0, 0, 32'h0,         0, 0, 1, 32'h0,        32'h24,       1, 0, 0, 0);
        add("retudf",    0, 0, 0, 32'h0,         0, 0, 1, 32'h0,        32'h28,       1, 0, 1, 0);
        add("udfclr",    0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h2C,       1, 0, 0, 0);
        add("call700",   0, 0, 0, 32'h0,         1, 1, 0, 32'h700,      32'h700,      0, 0, 0, 0);
        add("hold0",     0, 1, 0, 32'h0,         0, 0, 1, 32'h0,        32'h700,      0, 0, 0, 0);
        add("hold1",     0, 1, 0, 32'h0,         0, 0, 1, 32'h0,        32'h700,      0, 0, 0, 0);
        add("hold2",     0, 1, 0, 32'h0,         0, 0, 1, 32'h0,        32'h700,      0, 0, 0, 0);
        add("holdrel",   0, 0, 0, 32'h0,         0, 0, 1, 32'h0,        32'h30,       1, 0, 0, 0);
        add("holdempty", 0, 1, 0, 32'h0,         0, 0, 1, 32'h0,        32'h30,       1, 0, 0, 0);
        add("udf2",      0, 0, 0, 32'h0,         0, 0, 1, 32'h0,        32'h34,       1, 0, 1, 0);
        add("seq38",     0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h38,       1, 0, 0, 0);
        add("rstcall",   1, 0, 0, 32'h0,         1, 1, 0, 32'h900,      32'h100,      1, 0, 0, 0);
        add("postrst",   0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h104,      1, 0, 0, 0);
        add("nopush",    0, 0, 0, 32'h0,         0, 0, 1, 32'h0,        32'h108,      1, 0, 1, 0);
        add("jmpwrap",   0, 0, 0, 32'h0,         1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0, 0);
        add("seqwrap",   0, 0, 0, 32'h0,         0, 0, 0, 32'h0,        32'h0,        1, 0, 0, 0);
        add("brfwd",     0, 0, 1, 32'h24,        0, 0, 0, 32'h0,        32'h24,       1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; hold = vecs[i].hold; br = vecs[i].br; off = vecs[i].off;
            jmp = vecs[i].jmp; call = vecs[i].call; ret = vecs[i].ret; tgt = vecs[i].tgt;
            @(posedge clk);
            #1;
            chk({vecs[i].tag, " pc"},        pc,         vecs[i].pc);
            chk({vecs[i].tag, " empty"},     32'(e),     32'(vecs[i].e));
            chk({vecs[i].tag, " full"},      32'(f),     32'(vecs[i].f));
            chk({vecs[i].tag, " underflow"}, 32'(uf),    32'(vecs[i].uf));
            chk({vecs[i].tag, " overflow"},  32'(of),    32'(vecs[i].of));
        end

        // 8-bit wrap and reset asserted together with a call
        @(negedge clk);
        rst8 = 1'b1;
        @(posedge clk); #1;
        chk("w8 reset pc", 32'(pc8), 32'h20);
        chk("w8 reset empty", 32'(e8), 32'h1);
        @(negedge clk);
        rst8 = 1'b0; jmp8 = 1'b1; tgt8 = 8'hFC;
        @(posedge clk); #1;
        chk("w8 jmpFC pc", 32'(pc8), 32'hFC);
        @(negedge clk);
        jmp8 = 1'b0;
        @(posedge clk); #1;
        chk("w8 seq wrap pc", 32'(pc8), 32'h00);
        @(negedge clk);
        br8 = 1'b1; off8 = 8'hF8;
        @(posedge clk); #1;
        chk("w8 branch back wrap pc", 32'(pc8), 32'hF8);
        @(negedge clk);
        br8 = 1'b0; rst8 = 1'b1; jmp8 = 1'b1; call8 = 1'b1; tgt8 = 8'h80;
        @(posedge clk); #1;
        chk("w8 rst+call pc", 32'(pc8), 32'h20);
        chk("w8 rst+call empty", 32'(e8), 32'h1);
        chk("w8 rst+call overflow", 32'(of8), 32'h0);
        @(negedge clk);
        rst8 = 1'b0; jmp8 = 1'b0; call8 = 1'b0;
        @(posedge clk); #1;
        chk("w8 post rst pc", 32'(pc8), 32'h24);
        chk("w8 post rst empty", 32'(e8), 32'h1);
        chk("w8 post rst full", 32'(f8), 32'h0);
        chk("w8 post rst underflow", 32'(uf8), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
